// File: rtl/sle_bank_ctrl.sv
// Bank controller for WIDTH SLE cells: round-robin write arbitration between two clients,
// sync-load init sequencing, post-write hold gap. Optional shadow check under SLE_SHADOW_EN.
module sle_bank_ctrl #(
    parameter int               WIDTH        = 8,
    parameter int               INIT_CYCLES  = 2,
    parameter int               HOLD_CYCLES  = 1,
    parameter logic [WIDTH-1:0] INIT_RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req0,
    input  logic [WIDTH-1:0] i_data0,
    output logic             o_gnt0,
    input  logic             i_req1,
    input  logic [WIDTH-1:0] i_data1,
    output logic             o_gnt1,
    input  logic             i_init_req,
    input  logic [WIDTH-1:0] i_init_val,
    output logic             o_init_done,
    output logic             o_busy,
    output logic [WIDTH-1:0] o_sle_d,
    output logic             o_sle_en,
    output logic             o_sle_sln,
    output logic [WIDTH-1:0] o_sle_sd,
`ifdef SLE_SHADOW_EN
    input  logic [WIDTH-1:0] i_sle_q,
    output logic             o_shadow_err,
`endif
    output logic             o_sle_lat
);

    localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [ICW-1:0] INIT_LOAD = ICW'(INIT_CYCLES - 1);
    localparam logic [HCW-1:0] HOLD_LOAD = (HOLD_CYCLES > 0) ? HCW'(HOLD_CYCLES - 1) : '0;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic [ICW-1:0]   r_init_cnt;
    logic [HCW-1:0]   r_hold_cnt;
    logic             r_rr;
    logic             w_grant, w_win, w_init_acc;
    logic [WIDTH-1:0] w_wdata;
    logic             w_sln_nxt, w_en_nxt, w_gnt0_nxt, w_gnt1_nxt, w_done_nxt, w_busy_nxt;

    assign o_sle_lat = 1'b0;
    assign w_wdata   = w_win ? i_data1 : i_data0;

    // r_rr holds the last granted requester; a tie goes to the other one
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_win       = 1'b0;
        w_init_acc  = 1'b0;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == '0) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (i_init_req) begin
                    w_init_acc  = 1'b1;
                    w_state_nxt = ST_INIT;
                end else if (i_req0 || i_req1) begin
                    w_grant     = 1'b1;
                    w_win       = (i_req0 && i_req1) ? ~r_rr : i_req1;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                w_state_nxt = (HOLD_CYCLES > 0) ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD: begin
                if (i_init_req) begin
                    w_init_acc  = 1'b1;
                    w_state_nxt = ST_INIT;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // Output values for the coming cycle, registered below
    always_comb begin
        w_sln_nxt  = (w_state_nxt != ST_INIT);
        w_en_nxt   = (w_state_nxt == ST_WRITE);
        w_gnt0_nxt = w_grant && !w_win;
        w_gnt1_nxt = w_grant && w_win;
        w_done_nxt = (r_state == ST_INIT) && (w_state_nxt == ST_IDLE);
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_INIT;
            r_init_cnt  <= INIT_LOAD;
            r_hold_cnt  <= '0;
            r_rr        <= 1'b1;
            o_sle_d     <= '0;
            o_sle_sd    <= INIT_RST_VAL;
            o_sle_sln   <= 1'b0;
            o_sle_en    <= 1'b0;
            o_gnt0      <= 1'b0;
            o_gnt1      <= 1'b0;
            o_init_done <= 1'b0;
            o_busy      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_init_acc)
                r_init_cnt <= INIT_LOAD;
            else if (r_state == ST_INIT && r_init_cnt != '0)
                r_init_cnt <= r_init_cnt - 1'b1;
            if (r_state == ST_WRITE)
                r_hold_cnt <= HOLD_LOAD;
            else if (r_state == ST_HOLD && r_hold_cnt != '0)
                r_hold_cnt <= r_hold_cnt - 1'b1;
            if (w_grant) begin
                r_rr    <= w_win;
                o_sle_d <= w_wdata;
            end
            if (w_init_acc) o_sle_sd <= i_init_val;
            o_sle_sln   <= w_sln_nxt;
            o_sle_en    <= w_en_nxt;
            o_gnt0      <= w_gnt0_nxt;
            o_gnt1      <= w_gnt1_nxt;
            o_init_done <= w_done_nxt;
            o_busy      <= w_busy_nxt;
        end
    end

`ifdef SLE_SHADOW_EN
    logic [WIDTH-1:0] r_shadow;
    logic             r_idle_prev;

    // First IDLE cycle after a write or init is skipped so the bank has settled
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow     <= INIT_RST_VAL;
            r_idle_prev  <= 1'b0;
            o_shadow_err <= 1'b0;
        end else begin
            if (w_grant)         r_shadow <= w_wdata;
            else if (w_init_acc) r_shadow <= i_init_val;
            r_idle_prev <= (r_state == ST_IDLE);
            if (w_init_acc)
                o_shadow_err <= 1'b0;
            else if (r_state == ST_IDLE && r_idle_prev && i_sle_q != r_shadow)
                o_shadow_err <= 1'b1;
        end
    end
`endif

endmodule
